// File: rtl/serial_ctrl_pkg.sv
// Shared types and defaults for the serial frame receiver.
// Holds the receiver state encoding and the default frame geometry.
package serial_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   localparam int   DATA_W_DEF     = 8;
   localparam logic IDLE_LEVEL_DEF = 1'b1;

endpackage

// File: rtl/shift_register_en.sv
// MSB-first serial-in/parallel-out shift register with enable.
// Clears synchronously on rst.
module shift_register_en #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sh_en,
   input  logic              sIn,
   output logic [DATA_W-1:0] q
);

   // New bits enter at the LSB so the first bit received ends up as the MSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (sh_en) begin
         q <= {q[DATA_W-2:0], sIn};
      end
   end

endmodule

// File: rtl/serial_frame_controller.sv
// Frame sequencer: detects the start bit, gates DATA_W shifts, checks the stop bit
// and hands completed bytes to a consumer via a valid/ready holding register.
module serial_frame_controller
   import serial_ctrl_pkg::*;
#(
   parameter int   DATA_W     = DATA_W_DEF,
   parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sIn,
   input  logic                      rdy,
   output logic [DATA_W-1:0]         PO,
   output logic                      valid,
   output logic                      busy,
   output logic                      frame_err,
   output logic                      overrun,
   output logic [$clog2(DATA_W):0]   bit_cnt
);

   localparam int                CNT_W    = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

   rx_state_t         state;
   logic              shEn;
   logic [DATA_W-1:0] srQ;

   assign shEn = (state == DATA);
   assign busy = (state != IDLE);

   shift_register_en #(
      .DATA_W (DATA_W)
   ) uShift (
      .clk   (clk),
      .rst   (rst),
      .sh_en (shEn),
      .sIn   (sIn),
      .q     (srQ)
   );

   // A completing byte may overwrite valid in the same edge it is consumed,
   // so the consume clear is written first and the completion load wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         PO        <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (valid && rdy) begin
            valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (sIn == ~IDLE_LEVEL) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  state <= STOP;
               end
            end
            STOP: begin
               if (sIn == IDLE_LEVEL) begin
                  state <= IDLE;
                  if (!valid || rdy) begin
                     PO    <= srQ;
                     valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else begin
                  frame_err <= 1'b1;
                  state     <= BREAK;
               end
            end
            BREAK: begin
               if (sIn == IDLE_LEVEL) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_frame_controller.sv
// Directed self-checking bench for serial_frame_controller.
// Each stimulus step is one clock edge; outputs are sampled 1 ns after that edge.
module tb_serial_frame_controller;

   logic       clk;
   logic       rst;
   logic       sIn;
   logic       rdy;
   logic [7:0] PO;
   logic       valid;
   logic       busy;
   logic       frame_err;
   logic       overrun;
   logic [3:0] bit_cnt;

   int compareCount;
   int failCount;

   serial_frame_controller #(
      .DATA_W     (8),
      .IDLE_LEVEL (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sIn       (sIn),
      .rdy       (rdy),
      .PO        (PO),
      .valid     (valid),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun),
      .bit_cnt   (bit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic r, input logic rs);
      sIn = s;
      rdy = r;
      rst = rs;
      @(posedge clk);
      #1;
   endtask

   // Start bit, eight data bits MSB first, then the stop bit with its own rdy level.
   task automatic sendFrame(input logic [7:0] d, input logic stopBit, input logic rdyData, input logic rdyStop);
      applyStimulus(1'b0, rdyData, 1'b0);
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(d[i], rdyData, 1'b0);
      end
      applyStimulus(stopBit, rdyStop, 1'b0);
   endtask

   initial begin
      compareCount = 0;
      failCount    = 0;
      sIn = 1'b1;
      rdy = 1'b0;
      rst = 1'b1;

      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("rst_po", PO, 8'h00);
      checkOutput("rst_valid", valid, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_ferr", frame_err, 1'b0);
      checkOutput("rst_ovr", overrun, 1'b0);
      checkOutput("rst_bitcnt", bit_cnt, 4'd0);
      applyStimulus(1'b1, 1'b0, 1'b0);

      sendFrame(8'hA5, 1'b1, 1'b1, 1'b1);
      checkOutput("a5_po", PO, 8'hA5);
      checkOutput("a5_valid", valid, 1'b1);
      checkOutput("a5_ferr", frame_err, 1'b0);
      checkOutput("a5_busy", busy, 1'b0);
      checkOutput("a5_bitcnt", bit_cnt, 4'd8);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("a5_consumed", valid, 1'b0);
      checkOutput("a5_po_hold", PO, 8'hA5);

      sendFrame(8'h3C, 1'b0, 1'b1, 1'b1);
      checkOutput("fe_pulse", frame_err, 1'b1);
      checkOutput("fe_valid", valid, 1'b0);
      checkOutput("fe_busy", busy, 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         checkOutput("fe_once", frame_err, 1'b0);
         checkOutput("brk_busy", busy, 1'b1);
      end
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("brk_exit", busy, 1'b0);
      checkOutput("fe_po_keep", PO, 8'hA5);
      checkOutput("fe_nvalid", valid, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);

      sendFrame(8'h81, 1'b1, 1'b0, 1'b0);
      checkOutput("ov1_po", PO, 8'h81);
      checkOutput("ov1_valid", valid, 1'b1);
      checkOutput("ov1_ovr", overrun, 1'b0);
      sendFrame(8'h7E, 1'b1, 1'b0, 1'b0);
      checkOutput("ov2_ovr", overrun, 1'b1);
      checkOutput("ov2_po", PO, 8'h81);
      checkOutput("ov2_valid", valid, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("ov_consumed", valid, 1'b0);
      checkOutput("ov_sticky", overrun, 1'b1);

      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("mid_busy", busy, 1'b1);
      checkOutput("mid_bitcnt", bit_cnt, 4'd3);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("mrst_busy", busy, 1'b0);
      checkOutput("mrst_po", PO, 8'h00);
      checkOutput("mrst_valid", valid, 1'b0);
      checkOutput("mrst_ovr", overrun, 1'b0);
      checkOutput("mrst_ferr", frame_err, 1'b0);
      checkOutput("mrst_bitcnt", bit_cnt, 4'd0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      sendFrame(8'h55, 1'b1, 1'b1, 1'b1);
      checkOutput("f55_po", PO, 8'h55);
      checkOutput("f55_valid", valid, 1'b1);
      checkOutput("f55_ferr", frame_err, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("f55_consumed", valid, 1'b0);

      sendFrame(8'h12, 1'b1, 1'b0, 1'b0);
      checkOutput("sc1_po", PO, 8'h12);
      checkOutput("sc1_valid", valid, 1'b1);
      sendFrame(8'h34, 1'b1, 1'b0, 1'b1);
      checkOutput("sc2_valid", valid, 1'b1);
      checkOutput("sc2_po", PO, 8'h34);
      checkOutput("sc2_ovr", overrun, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("sc2_consumed", valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule

// File: doc/serial_frame_controller.md
Name: serial_frame_controller

Overview:
Sequencing controller for the 8-bit serial shift register. It watches the serial line `sIn` for a start bit and gates exactly DATA_W shift cycles. It then checks the stop bit and transfers the assembled byte into a holding register with a valid/ready handshake. It sits between the raw serial input and any byte-wide consumer, and flags framing and overrun errors.

Parameters:
DATA_W, 8, number of data bits per frame; equals the shift register width.
IDLE_LEVEL, 1, line level when idle; the start bit is !IDLE_LEVEL and the stop bit is IDLE_LEVEL.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset; dominates every other input.
sIn  input  1  serial line, one bit per clk cycle, MSB first.
rdy  input  1  consumer ready; a byte transfers on an edge where valid=1 and rdy=1.
PO  output  DATA_W  holding register (last accepted byte).
valid  output  1  PO holds an unconsumed byte.
busy  output  1  high whenever state != IDLE.
frame_err  output  1  one-cycle pulse when the stop bit is bad.
overrun  output  1  sticky; set when a byte is dropped; cleared only by rst.
bit_cnt  output  $clog2(DATA_W)+1  data bits captured in the current frame (debug).

Behaviour:
- Reset (edge with rst=1):
  - state=IDLE, shift register=0, bit_cnt=0.
  - PO=0, valid=0, busy=0, frame_err=0, overrun=0.
  - Reset mid-frame abandons the frame with no error flag.
- States: IDLE, DATA, STOP, BREAK.
- IDLE:
  - sIn==!IDLE_LEVEL at edge N → DATA, bit_cnt=0.
  - Otherwise stay in IDLE.
- DATA:
  - At each edge, shift: sr <= {sr[DATA_W-2:0], sIn}; bit_cnt++.
  - Data bits are sampled at edges N+1 … N+DATA_W.
  - When bit_cnt reaches DATA_W → STOP.
- STOP: the stop bit is sampled at edge N+DATA_W+1.
  - sIn==IDLE_LEVEL: byte complete → IDLE.
  - Otherwise: frame_err=1 for exactly one cycle, byte discarded → BREAK.
- BREAK:
  - Stay until sIn==IDLE_LEVEL is sampled at an edge, then → IDLE.
  - A line stuck at !IDLE_LEVEL never starts a new frame.
- Byte completion (good stop at edge S):
  - Case valid=0, or valid=1 and rdy=1: PO<=sr, valid=1 after edge S. A simultaneous consume and new byte keeps valid=1 with the new PO.
  - Case valid=1 and rdy=0: byte dropped, PO unchanged, overrun<=1.
- Handshake:
  - valid=1, rdy=1 at an edge with no completion → valid=0 after that edge.
  - valid stays high indefinitely while rdy=0.
  - PO is stable while valid=1.
- Latency and throughput:
  - Start bit at edge N → valid visible after edge N+DATA_W+1.
  - Back-to-back frames are allowed: the next start bit may be sampled at edge N+DATA_W+2.
- Shift register contents are not cleared between frames; only PO is architecturally visible.
- The receiver never stalls on rdy; the holding register decouples the line from the consumer.

Decomposition:
- Package serial_ctrl_pkg:
  - state enum rx_state_t {IDLE, DATA, STOP, BREAK}.
  - Default constants DATA_W_DEF=8 and IDLE_LEVEL_DEF=1.
- Sub-module shift_register_en:
  - Parameterised DATA_W.
  - Ports clk, rst, sh_en, sIn, q.
  - MSB-first shift when sh_en=1; sync clear on rst.
- The controller drives sh_en=1 only in DATA and owns the counter, FSM, PO register, valid and flags.

Test Plan:
1. Reset: rst=1 for 2 cycles with sIn toggling → PO=0x00, valid=0, busy=0, frame_err=0, overrun=0, bit_cnt=0.
2. Single frame: sIn=0, then 1,0,1,0,0,1,0,1, then 1; rdy=1 → after stop edge PO=0xA5, valid=1 for exactly 1 cycle, frame_err=0, busy back to 0.
3. Framing error: frame 0x3C with stop=0, then sIn=0 for 3 cycles, then 1 → frame_err pulses 1 cycle, valid stays 0, busy=1 through BREAK, IDLE one cycle after sIn=1 is sampled.
4. Backpressure/overrun: rdy=0, send 0x81 then 0x7E back-to-back → PO=0x81 with valid held, overrun=1 after the second stop, PO still 0x81; then rdy=1 → valid=0 next cycle, overrun stays 1.
5. Reset mid-frame: rst pulsed during data bit 4 of 0xF0 → all outputs 0 and IDLE next cycle; a following frame 0x55 is received correctly with no frame_err.
6. Simultaneous consume/complete: valid=1 (0x12), rdy=1 exactly on the stop edge of 0x34 → valid stays 1, PO=0x34, overrun=0.
